cpc_bus_sequencer: RTL

//  Parametrised bus-cycle sequencer for the CPC motherboard: generates the N-phase bus slot counter,
//  Z80 wait insertion, CRTC/PSG clock enables and a round-robin DMA slot shared by DMA_CH requesters.

---
 rtl/cpc_bus_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cpc_bus_sequencer.sv
// CPC bus-cycle sequencer: bus phase counter with resync, Z80 wait generation,
// CRTC/PSG clock enables, round-robin DMA slot arbitration and a saturating
// wait-state counter.
module cpc_bus_sequencer #(
  parameter int unsigned PHASES    = 4,
  parameter int unsigned CPU_PHASE = 0,
  parameter int unsigned DMA_PHASE = 2,
  parameter int unsigned DMA_CH    = 3,
  parameter int unsigned PW        = $clog2(PHASES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_p,
  input  logic              ce_n,
  input  logic              resync,
  input  logic              no_wait,
  input  logic              mreq_n,
  input  logic              iorq_n,
  output logic [PW-1:0]     phase,
  output logic              cpu_wait_n,
  output logic              crtc_ce,
  output logic              psg_ce,
  input  logic [DMA_CH-1:0] dma_req,
  output logic [DMA_CH-1:0] dma_grant,
  output logic [DMA_CH-1:0] dma_done,
  input  logic              wait_clr,
  output logic [15:0]       wait_cnt
);

  localparam int unsigned    CW     = (DMA_CH > 1) ? $clog2(DMA_CH) : 1;
  localparam logic [PW-1:0]  LAST_P = PW'(PHASES - 1);
  localparam logic [PW-1:0]  CPU_P  = PW'(CPU_PHASE);
  localparam logic [PW-1:0]  DMA_P  = PW'(DMA_PHASE);

  logic [PW-1:0]     phase_q, phase_d;
  logic              resync_pend_q, resync_pend_d;
  logic [DMA_CH-1:0] grant_q, grant_d;
  logic [DMA_CH-1:0] done_q, done_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              wait_n;
  logic              found;
  logic [CW-1:0]     idx;

  assign wait_n     = (phase_q == CPU_P) | (mreq_n & iorq_n) | no_wait;
  assign cpu_wait_n = wait_n;
  assign crtc_ce    = ce_p & (phase_q == CPU_P);
  assign psg_ce     = ce_n & (phase_q == CPU_P);
  assign phase      = phase_q;
  assign dma_grant  = grant_q;
  assign dma_done   = done_q;
  assign wait_cnt   = wcnt_q;

  // Phase advance on ce_p; a pending or simultaneous resync forces phase 0.
  always_comb begin
    phase_d       = phase_q;
    resync_pend_d = resync_pend_q | resync;
    if (ce_p) begin
      resync_pend_d = 1'b0;
      if (resync_pend_q | resync) begin
        phase_d = '0;
      end else if (phase_q == LAST_P) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // DMA slot: close the slot on the ce_p leaving DMA_PHASE, then arbitrate
  // round robin from rr_q if the same edge enters DMA_PHASE.
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    rr_d    = rr_q;
    found   = 1'b0;
    idx     = '0;
    if (ce_p) begin
      if (phase_q == DMA_P) begin
        grant_d = '0;
        done_d  = grant_q;
      end
      if (phase_d == DMA_P) begin
        grant_d = '0;
        for (int unsigned i = 0; i < DMA_CH; i++) begin
          idx = CW'((32'(rr_q) + i) % DMA_CH);
          if (!found && dma_req[idx]) begin
            found        = 1'b1;
            grant_d      = '0;
            grant_d[idx] = 1'b1;
            rr_d         = CW'((32'(idx) + 1) % DMA_CH);
          end
        end
      end
    end
  end

  // Saturating count of stalled ce_p cycles; clear has priority.
  always_comb begin
    wcnt_d = wcnt_q;
    if (wait_clr) begin
      wcnt_d = '0;
    end else if (ce_p && !wait_n && (wcnt_q != 16'hFFFF)) begin
      wcnt_d = wcnt_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q       <= '0;
      resync_pend_q <= 1'b0;
      grant_q       <= '0;
      done_q        <= '0;
      rr_q          <= '0;
      wcnt_q        <= '0;
    end else begin
      phase_q       <= phase_d;
      resync_pend_q <= resync_pend_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      rr_q          <= rr_d;
      wcnt_q        <= wcnt_d;
    end
  end

endmodule
